i2c_arbiter: RTL
================

# i2c_arbiter

Round-robin scheduler that shares the single I2C master between NUM_REQ requesters. It drives the master's command fields (start, speed, read/write, address, write data), watches its ready bit, and returns the read byte and a completion pulse to the winning requester. It sits between the command sources (sensor pollers, config loaders) and the I2C master's 32-bit control word, and it owns every start and reset of that master.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 16'd40000: watchdog limit in clk cycles per transaction (used only with I2C_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock (16 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request per requester; held until its done pulse.
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_speed  in  NUM_REQ  0 = 100 kbps, 1 = 400 kbps.
- req_addr  in  7*NUM_REQ  7-bit slave address, requester i at [7i+6:7i].
- req_wdata  in  8*NUM_REQ  write byte, requester i at [8i+7:8i].
- gnt  out  NUM_REQ  one-hot grant, held from issue to done.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  8  read byte; valid in the done cycle, held until the next done.
- rsp_err  out  1  valid with done; 1 = aborted by watchdog.
- busy  out  1  high whenever state != IDLE.
- m_start, m_reset  out  1  one-cycle pulses to master bit 0 and bit 1.
- m_speed, m_rw  out  1  to master bits 2 and 3.
- m_addr  out  7  to master bits 10:4.
- m_wdata  out  8  to master bits 18:11.
- m_rdata  in  8  from master bits 18:11.
- m_ready  in  1  from master bit 19; 1 = idle.

## Operation
- Reset: all outputs 0; state IDLE; round-robin pointer = 0; watchdog = 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE, ABORT.
- IDLE: if (|req) and m_ready, pick the first set req at or after the pointer (wrapping). Register gnt, m_speed, m_rw, m_addr, m_wdata from that requester and go to ISSUE. Otherwise stay.
- ISSUE: m_start = 1 for this cycle only. Go to WAIT_BUSY.
- WAIT_BUSY: when m_ready = 0, go to WAIT_DONE.
- WAIT_DONE: when m_ready = 1, capture m_rdata into rsp_rdata (write transactions also capture) and go to DONE.
- DONE: done[granted] = 1, rsp_err = 0. Pointer = granted index + 1 mod NUM_REQ. Clear gnt. Go to IDLE.
- ABORT (timeout only): m_reset = 1 for one cycle; then same as DONE but with rsp_err = 1.
- Command fields stay stable from ISSUE until the cycle after done.
- A req dropped mid-transaction is ignored; the transaction still completes and done still pulses.
- A req held high after its done is a new request. It is arbitrated at the next IDLE behind the other pending requesters.

## Timing
- Arbitration edge to m_start: m_start is high in the first cycle after the edge where IDLE sees req.
- Minimum req-to-done latency is 4 cycles plus the master's busy time.
- Back-to-back: a new grant is possible in the cycle after DONE; at most one transaction runs at a time.
- Simultaneous requests: exactly one grant per arbitration; the pointer guarantees each pending requester is served within NUM_REQ transactions.
- Reset mid-transaction: everything returns to reset values immediately. No done is issued and m_reset is not pulsed; the master is reset by the shared rst.

## Configuration
- I2C_ARB_TIMEOUT_EN defined: a 16-bit watchdog clears on ISSUE and counts in WAIT_BUSY and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES - 1 in either state goes to ABORT.
  - This covers a master stuck waiting for a missing ACK.
- I2C_ARB_TIMEOUT_EN undefined: no watchdog and no ABORT state; rsp_err is tied to 0 and m_reset is tied to 0.

## Test plan
- Single write: req[0] with addr 7'h48, wdata 8'hA5, rw=0, speed=1. Required: one m_start pulse with m_addr=7'h48, m_wdata=8'hA5, m_speed=1; done[0] one cycle after m_ready rises; rsp_err=0.
- Read: req[2] with rw=1 while the master model returns 8'h3C. Required: rsp_rdata=8'h3C in the done[2] cycle and held afterwards.
- Fairness: req=4'b1111 held continuously. Required: grant order 0,1,2,3,0,…, with exactly one m_start per transaction.
- Requests on wrap-around: pointer=3 and req=4'b1001. Required: requester 3 is granted, then requester 0.
- Timeout (macro on, TIMEOUT_CYCLES=100): the master never raises m_ready again. Required: m_reset pulse, then done with rsp_err=1, then the next requester is granted.
- Reset mid-transaction: rst_n low during WAIT_DONE. Required: gnt=0, busy=0, no done pulse, and normal arbitration after release.

Source files
------------

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin scheduler sharing one I2C master among NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to add the per-transaction watchdog and ABORT path.
module i2c_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [NUM_REQ-1:0]   req_speed,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 m_start,
    output logic                 m_reset,
    output logic                 m_speed,
    output logic                 m_rw,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_wdata,
    input  logic [7:0]           m_rdata,
    input  logic                 m_ready
);
    localparam int IW = $clog2(NUM_REQ);
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 16'd2) begin : g_bad_cfg
        $error("i2c_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end
    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE
`ifdef I2C_ARB_TIMEOUT_EN
        , ABORT
`endif
    } state_t;
    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d, idx_q, idx_d, pick;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 speed_q, speed_d, rw_q, rw_d;
    logic [6:0]           addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
    logic                 err_q, err_d;
    logic [15:0]          wd_q, wd_d;
    logic                 expired;
    assign expired = wd_q == TIMEOUT_CYCLES - 16'd1;
`endif
    // Scan downwards so the lowest offset from the pointer wins.
    always_comb begin
        pick = ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % NUM_REQ]) pick = IW'((int'(ptr_q) + k) % NUM_REQ);
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        speed_d = speed_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
        err_d   = err_q;
        wd_d    = wd_q;
`endif
        case (state_q)
            IDLE: if (|req && m_ready) begin
                state_d = ISSUE;
                idx_d   = pick;
                gnt_d   = NUM_REQ'(1) << pick;
                speed_d = req_speed[pick];
                rw_d    = req_rw[pick];
                addr_d  = req_addr[7*int'(pick) +: 7];
                wdata_d = req_wdata[8*int'(pick) +: 8];
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            WAIT_BUSY: begin
`ifdef I2C_ARB_TIMEOUT_EN
                wd_d    = wd_q + 16'd1;
                state_d = expired ? ABORT : (!m_ready ? WAIT_DONE : WAIT_BUSY);
`else
                state_d = !m_ready ? WAIT_DONE : WAIT_BUSY;
`endif
            end
            WAIT_DONE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                wd_d = wd_q + 16'd1;
                if (expired) state_d = ABORT;
                else if (m_ready) begin
                    state_d = DONE;
                    rdata_d = m_rdata;
                    err_d   = 1'b0;
                end
`else
                if (m_ready) begin
                    state_d = DONE;
                    rdata_d = m_rdata;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            ABORT: begin
                state_d = DONE;
                err_d   = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            speed_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            speed_q <= speed_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q   <= err_d;
            wd_q    <= wd_d;
`endif
        end
    end
    assign gnt       = gnt_q;
    assign done      = gnt_q & {NUM_REQ{state_q == DONE}};
    assign rsp_rdata = rdata_q;
    assign busy      = state_q != IDLE;
    assign m_start   = state_q == ISSUE;
    assign m_speed   = speed_q;
    assign m_rw      = rw_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign rsp_err   = err_q;
    assign m_reset   = state_q == ABORT;
`else
    assign rsp_err   = 1'b0;
    assign m_reset   = 1'b0;
`endif
endmodule
